// File: rtl/timer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// timer_arb_pkg
// Shared types and helpers for the timer_arbiter block.
//   state_t  : arbiter FSM states (IDLE, RUN, FIN)
//   pick_t   : result of a round-robin search (valid flag + index)
//   rr_pick  : first set request bit at or after a pointer, wrapping mod n
// The search is written for up to MAX_REQ requesters; callers zero-extend
// their request vector and pass their real requester count in n.
// ---------------------------------------------------------------------------
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = $clog2(MAX_REQ);

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n);
        pick_t r;
        int    idx;
        r.vld = 1'b0;
        r.idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !r.vld) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx]) begin
                    r.vld = 1'b1;
                    r.idx = MAX_ID_W'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// ---------------------------------------------------------------------------
// timer_arbiter_if
// Requester-side bus of the shared timer.
//   req       : level request per requester
//   dur       : per-requester duration in base ticks, slice [i*CNT_W +: CNT_W]
//   gnt       : one-hot grant
//   done      : one-cycle expiry pulse to the owner
//   busy      : a grant is active
//   active_id : index of the current / last owner
// With TIMER_ARB_ABORT_FLAG_EN defined, two more signals exist:
//   aborted   : one-cycle pulse to the owner when it drops req early
//   abort_cnt : saturating count of aborts
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface timer_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] dur;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [ID_W-1:0]        active_id;
`ifdef TIMER_ARB_ABORT_FLAG_EN
    logic [N_REQ-1:0]       aborted;
    logic [7:0]             abort_cnt;

    modport master (output req, dur,
                    input  gnt, done, busy, active_id, aborted, abort_cnt);
    modport slave  (input  req, dur,
                    output gnt, done, busy, active_id, aborted, abort_cnt);
`else
    modport master (output req, dur,
                    input  gnt, done, busy, active_id);
    modport slave  (input  req, dur,
                    output gnt, done, busy, active_id);
`endif

endinterface

// File: rtl/timer_arbiter_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Counts clk_50MHz cycles modulo PRESCALE and flags the wrap cycle.
//   clk_50MHz : system clock
//   reset     : asynchronous, active-high
//   clr       : hold the count at zero (restart on release)
//   tick      : high during the last cycle of each PRESCALE-cycle period
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int PRESCALE = 50_000
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] count;

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + PS_W'(1);
        end
    end

    assign tick = !clr && (count == LAST);

endmodule

// File: rtl/timer_arbiter.sv
// ---------------------------------------------------------------------------
// timer_arbiter
// One prescaled down-counter shared round-robin among N_REQ requesters.
// A granted requester loads its duration; the timer counts base ticks of
// PRESCALE clocks and returns a one-cycle done pulse on expiry. Dropping req
// while running aborts the grant without a done pulse.
// Ports:
//   clk_50MHz : system clock
//   reset     : asynchronous, active-high
//   bus       : timer_arbiter_if.slave (req, dur in; gnt, done, busy,
//               active_id out)
// Optional: define TIMER_ARB_ABORT_FLAG_EN to drive bus.aborted (abort pulse
// to the owner) and bus.abort_cnt (saturating abort count).
// ---------------------------------------------------------------------------
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int PRESCALE = 50_000,
    parameter int CNT_W    = 16
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    timer_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(N_REQ);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt, gnt_nxt;
    logic [N_REQ-1:0] done, done_nxt;
    logic             busy, busy_nxt;
    logic [ID_W-1:0]  active_id, active_id_nxt;
    logic             tick;
    logic             expire;
    logic [ID_W-1:0]  ptr_after_owner;
    pick_t            pick;

`ifdef TIMER_ARB_ABORT_FLAG_EN
    logic [N_REQ-1:0] aborted, aborted_nxt;
    logic [7:0]       abort_cnt, abort_cnt_nxt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    // Prescaler is held at zero outside RUN so each grant starts a full tick.
    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .clr       (state != RUN),
        .tick      (tick)
    );

    assign pick = rr_pick(MAX_REQ'(bus.req), MAX_ID_W'(rr_ptr), N_REQ);

    // Expiry: zero duration on entry, or the wrap that takes cnt from 1 to 0.
    // This gives done max(dur,1)*PRESCALE+1 cycles after grant for dur>0.
    assign expire = (cnt == '0) || (tick && cnt == CNT_W'(1));

    assign ptr_after_owner = (active_id == ID_W'(N_REQ - 1)) ? '0
                                                              : active_id + ID_W'(1);

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        done_nxt      = '0;
        busy_nxt      = busy;
        active_id_nxt = active_id;
`ifdef TIMER_ARB_ABORT_FLAG_EN
        aborted_nxt   = '0;
        abort_cnt_nxt = abort_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (pick.vld) begin
                    state_nxt     = RUN;
                    gnt_nxt       = N_REQ'(1) << pick.idx;
                    busy_nxt      = 1'b1;
                    active_id_nxt = pick.idx[ID_W-1:0];
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick.idx == MAX_ID_W'(i)) begin
                            cnt_nxt = bus.dur[i*CNT_W +: CNT_W];
                        end
                    end
                end
            end
            RUN: begin
                // Expiry is checked before abort so a same-edge req drop
                // still completes with a done pulse.
                if (expire) begin
                    state_nxt = FIN;
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end else if (!bus.req[active_id]) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    busy_nxt   = 1'b0;
                    rr_ptr_nxt = ptr_after_owner;
`ifdef TIMER_ARB_ABORT_FLAG_EN
                    aborted_nxt   = gnt;
                    abort_cnt_nxt = sat_inc8(abort_cnt);
`endif
                end else if (tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            FIN: begin
                // gnt is one-hot on the owner, so it doubles as the done mask.
                state_nxt  = IDLE;
                done_nxt   = gnt;
                gnt_nxt    = '0;
                busy_nxt   = 1'b0;
                rr_ptr_nxt = ptr_after_owner;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            active_id <= '0;
`ifdef TIMER_ARB_ABORT_FLAG_EN
            aborted   <= '0;
            abort_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            active_id <= active_id_nxt;
`ifdef TIMER_ARB_ABORT_FLAG_EN
            aborted   <= aborted_nxt;
            abort_cnt <= abort_cnt_nxt;
`endif
        end
    end

    assign bus.gnt       = gnt;
    assign bus.done      = done;
    assign bus.busy      = busy;
    assign bus.active_id = active_id;
`ifdef TIMER_ARB_ABORT_FLAG_EN
    assign bus.aborted   = aborted;
    assign bus.abort_cnt = abort_cnt;
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timer_arbiter
// Directed bench for timer_arbiter with N_REQ=4, PRESCALE=4, CNT_W=16.
// Builds with or without TIMER_ARB_ABORT_FLAG_EN.
// ---------------------------------------------------------------------------
module tb_timer_arbiter;
    localparam int N_REQ    = 4;
    localparam int PRESCALE = 4;
    localparam int CNT_W    = 16;

    logic clk_50MHz = 1'b0;
    logic reset     = 1'b1;

    always #10 clk_50MHz = ~clk_50MHz;

    timer_arbiter_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    timer_arbiter #(
        .N_REQ    (N_REQ),
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .bus       (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic set_dur(input int i, input int v);
        bus.dur[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Cycles from the current sample point until done is seen, capped at limit.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.done == '0 && n < limit);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        step();
        step();
        reset   = 1'b0;
    endtask

    function automatic int oh_idx(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) return i;
        end
        return 7;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        int got;
        int ord [4];
        int exp_ord [4];
        logic [N_REQ-1:0] prev;

        bus.req = '0;
        bus.dur = '0;
        reset   = 1'b1;
        step();
        step();

        // Reset state
        check("rst_gnt",  32'(bus.gnt),       32'h0);
        check("rst_done", 32'(bus.done),      32'h0);
        check("rst_busy", 32'(bus.busy),      32'h0);
        check("rst_id",   32'(bus.active_id), 32'h0);
`ifdef TIMER_ARB_ABORT_FLAG_EN
        check("rst_abort_cnt", 32'(bus.abort_cnt), 32'h0);
`endif

        // Single requester, dur=3: done 3*4+1 = 13 cycles after grant
        reset = 1'b0;
        set_dur(0, 3);
        bus.req = 4'b0001;
        step();
        check("t1_gnt",  32'(bus.gnt),       32'h1);
        check("t1_busy", 32'(bus.busy),      32'h1);
        check("t1_id",   32'(bus.active_id), 32'h0);
        wait_done(60, n);
        check("t1_latency",  32'(n),         32'd13);
        check("t1_done",     32'(bus.done),  32'h1);
        check("t1_busy_low", 32'(bus.busy),  32'h0);
        check("t1_gnt_low",  32'(bus.gnt),   32'h0);
        bus.req = '0;
        step();
        check("t1_done_pulse", 32'(bus.done), 32'h0);

        // Four simultaneous requesters, dur=1: order 0..3, 5-cycle latency,
        // next grant one cycle after each done
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_dur(i, 1);
        bus.req = 4'b1111;
        step();
        for (int k = 0; k < N_REQ; k++) begin
            check($sformatf("t2_gnt%0d", k), 32'(bus.gnt), 32'(1 << k));
            wait_done(30, n);
            check($sformatf("t2_latency%0d", k), 32'(n), 32'd5);
            check($sformatf("t2_done%0d", k), 32'(bus.done), 32'(1 << k));
            check($sformatf("t2_gap%0d", k), 32'(bus.gnt), 32'h0);
            bus.req[k] = 1'b0;
            step();
            if (k < N_REQ - 1) check($sformatf("t2_next%0d", k), 32'(bus.gnt), 32'(1 << (k + 1)));
            else               check("t2_idle", 32'(bus.gnt), 32'h0);
        end

        // Zero duration: gnt for 2 cycles, then done
        set_dur(2, 0);
        bus.req = 4'b0100;
        step();
        check("t3_gnt", 32'(bus.gnt), 32'h4);
        wait_done(20, n);
        check("t3_latency", 32'(n),        32'd2);
        check("t3_done",    32'(bus.done), 32'h4);
        bus.req = '0;
        step();
        check("t3_done_pulse", 32'(bus.done), 32'h0);
        check("t3_gnt_low",    32'(bus.gnt),  32'h0);

        // Abort: dur=10, req dropped 7 cycles after grant
        set_dur(1, 10);
        bus.req = 4'b0010;
        step();
        check("t4_gnt", 32'(bus.gnt), 32'h2);
        repeat (7) step();
        check("t4_gnt_hold", 32'(bus.gnt), 32'h2);
        bus.req[1] = 1'b0;
        step();
        check("t4_gnt_low",  32'(bus.gnt),  32'h0);
        check("t4_busy_low", 32'(bus.busy), 32'h0);
        check("t4_no_done",  32'(bus.done), 32'h0);
`ifdef TIMER_ARB_ABORT_FLAG_EN
        check("t4_aborted",   32'(bus.aborted),   32'h2);
        check("t4_abort_cnt", 32'(bus.abort_cnt), 32'd1);
`endif
        seen = 0;
        repeat (50) begin
            step();
            if (bus.done != '0) seen++;
        end
        check("t4_done_never", 32'(seen), 32'd0);
`ifdef TIMER_ARB_ABORT_FLAG_EN
        check("t4_aborted_pulse", 32'(bus.aborted), 32'h0);
`endif

        // req drop coinciding with the final wrap: completion wins
        set_dur(0, 1);
        bus.req = 4'b0001;
        step();
        check("t5_gnt", 32'(bus.gnt), 32'h1);
        repeat (3) step();
        bus.req[0] = 1'b0;
        step();
        check("t5_gnt_fin",  32'(bus.gnt),  32'h1);
        check("t5_busy_fin", 32'(bus.busy), 32'h1);
        step();
        check("t5_done", 32'(bus.done), 32'h1);
`ifdef TIMER_ARB_ABORT_FLAG_EN
        check("t5_abort_cnt", 32'(bus.abort_cnt), 32'd1);
`endif

        // Fairness: req[3] held continuously, req[0] joins -> 3,0,3,0
        set_dur(3, 0);
        set_dur(0, 0);
        bus.req = 4'b1000;
        step();
        check("t6_first", 32'(bus.gnt), 32'h8);
        bus.req[0] = 1'b1;
        ord     = '{7, 7, 7, 7};
        exp_ord = '{3, 0, 3, 0};
        ord[0]  = oh_idx(bus.gnt);
        got     = 1;
        prev    = bus.gnt;
        for (int c = 0; c < 80 && got < 4; c++) begin
            step();
            if (bus.gnt != '0 && prev == '0) begin
                ord[got] = oh_idx(bus.gnt);
                got++;
            end
            prev = bus.gnt;
        end
        for (int i = 0; i < 4; i++) check($sformatf("t6_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
        bus.req = '0;
        repeat (6) step();

        // Reset while running (cnt=5), then full reload after release
        set_dur(1, 8);
        bus.req = 4'b0010;
        step();
        check("t7_gnt", 32'(bus.gnt), 32'h2);
        repeat (13) step();
        reset = 1'b1;
        #1;
        check("t7_rst_gnt",  32'(bus.gnt),       32'h0);
        check("t7_rst_busy", 32'(bus.busy),      32'h0);
        check("t7_rst_done", 32'(bus.done),      32'h0);
        check("t7_rst_id",   32'(bus.active_id), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("t7_regnt", 32'(bus.gnt), 32'h2);
        wait_done(100, n);
        check("t7_latency", 32'(n),        32'd33);
        check("t7_done",    32'(bus.done), 32'h2);
        bus.req = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
